// File: rtl/pe_array_feeder.sv
// Job sequencer feeding a 1-D systolic PE row and serializing its results.
// Optional macro PE_FEEDER_STALL_CNT_EN adds a saturating STEP stall counter.
module pe_array_feeder #(
  parameter int ARRAY_NUM = 3,
  parameter int KMAX      = 16,
  parameter int DRAIN_LAT = 5,
  localparam int KW = $clog2(KMAX + 1),
  localparam int LW = $clog2(ARRAY_NUM)
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic [KW-1:0]          iKernelLen,
  output logic                   oBusy,
  output logic                   oDone,
  input  logic                   iDataValid,
  output logic                   oDataReady,
  input  logic [7:0]             iData,
  input  logic                   iWeightValid,
  output logic                   oWeightReady,
  input  logic [7:0]             iWeight,
  output logic [8*ARRAY_NUM-1:0] oArrData,
  output logic [ARRAY_NUM-2:0]   oArrPassLeft,
  output logic [7:0]             oArrWeight,
  output logic                   oArrClearAcc,
  input  logic [8*ARRAY_NUM-1:0] iArrResult,
`ifdef PE_FEEDER_STALL_CNT_EN
  output logic [15:0]            oStallCnt,
`endif
  output logic                   oResultValid,
  input  logic                   iResultReady,
  output logic [7:0]             oResult,
  output logic [LW-1:0]          oResultLane
);

  localparam int DW = $clog2(DRAIN_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATHER,
    S_STEP,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KW-1:0]                r_klen;
  logic [KW-1:0]                r_k;
  logic [LW-1:0]                r_gcnt;
  logic [LW-1:0]                r_lane;
  logic [DW-1:0]                r_dcnt;
  logic [ARRAY_NUM-1:0][7:0]    r_gather;
  logic [ARRAY_NUM-1:0][7:0]    r_snap;
  logic [ARRAY_NUM-1:0][7:0]    r_arr_data;
  logic [ARRAY_NUM-2:0]         r_pass;
  logic [7:0]                   r_weight;
  logic                         r_clear;
  logic                         r_done;

  logic w_k0;
  logic w_start_ok;
  logic w_data_rdy;
  logic w_wgt_rdy;
  logic w_data_acc;
  logic w_issue;
  logic w_last_tap;
  logic w_last_gather;
  logic w_last_lane;
  logic w_res_vld;
  logic w_res_acc;
  logic w_drain_end;

  always_comb begin
    w_k0          = (r_k == '0);
    w_start_ok    = iStart && !r_done &&
                    (iKernelLen != '0) &&
                    (iKernelLen <= KW'(KMAX));
    w_last_tap    = (r_k == r_klen - KW'(1));
    w_last_gather = (r_gcnt == LW'(ARRAY_NUM - 1));
    w_last_lane   = (r_lane == LW'(ARRAY_NUM - 1));
    w_drain_end   = (r_state == S_DRAIN) &&
                    (r_dcnt == DW'(DRAIN_LAT));
    w_data_rdy    = 1'b0;
    w_wgt_rdy     = 1'b0;
    unique case (r_state)
      S_GATHER: w_data_rdy = 1'b1;
      S_STEP: begin
        if (w_k0) begin
          w_wgt_rdy = 1'b1;
        end else begin
          // k>=1 taps need a data byte and a tap together
          w_wgt_rdy  = iDataValid;
          w_data_rdy = iWeightValid;
        end
      end
      default: ;
    endcase
    if (iRst) begin
      w_data_rdy = 1'b0;
      w_wgt_rdy  = 1'b0;
    end
    w_res_vld  = (r_state == S_UNLOAD) && !iRst;
    w_data_acc = w_data_rdy && iDataValid;
    w_issue    = w_wgt_rdy && iWeightValid;
    w_res_acc  = w_res_vld && iResultReady;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start_ok) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_GATHER;
      S_GATHER: if (w_data_acc && w_last_gather) w_next = S_STEP;
      S_STEP:   if (w_issue && w_last_tap) w_next = S_DRAIN;
      S_DRAIN:  if (w_drain_end) w_next = S_UNLOAD;
      S_UNLOAD: if (w_res_acc && w_last_lane) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_klen     <= '0;
      r_k        <= '0;
      r_gcnt     <= '0;
      r_lane     <= '0;
      r_dcnt     <= '0;
      r_gather   <= '0;
      r_snap     <= '0;
      r_arr_data <= '0;
      r_pass     <= '0;
      r_weight   <= '0;
      r_clear    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= w_res_acc && w_last_lane;
      r_clear  <= (r_state == S_CLEAR);
      r_weight <= w_issue ? iWeight : 8'h00;
      r_pass   <= (w_issue && !w_k0) ? '1 : '0;
      if (w_issue) begin
        if (w_k0) r_arr_data <= r_gather;
        else      r_arr_data[ARRAY_NUM-1] <= iData;
        r_k <= r_k + KW'(1);
      end
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_klen <= iKernelLen;
        r_k    <= '0;
        r_gcnt <= '0;
        r_lane <= '0;
        r_dcnt <= '0;
      end
      if ((r_state == S_GATHER) && w_data_acc) begin
        r_gather[r_gcnt] <= iData;
        r_gcnt           <= r_gcnt + LW'(1);
      end
      if (r_state == S_DRAIN) begin
        r_dcnt <= r_dcnt + DW'(1);
        if (w_drain_end) r_snap <= iArrResult;
      end
      if (w_res_acc) begin
        r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
      end
    end
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge iClk) begin
    if (iRst || (r_state == S_CLEAR)) begin
      r_stall <= '0;
    end else if ((r_state == S_STEP) && !w_issue &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign oStallCnt = r_stall;
`endif

  assign oBusy        = (r_state != S_IDLE);
  assign oDone        = r_done;
  assign oDataReady   = w_data_rdy;
  assign oWeightReady = w_wgt_rdy;
  assign oArrData     = r_arr_data;
  assign oArrPassLeft = r_pass;
  assign oArrWeight   = r_weight;
  assign oArrClearAcc = r_clear;
  assign oResultValid = w_res_vld;
  assign oResult      = r_snap[r_lane];
  assign oResultLane  = r_lane;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder with issue and result scoreboards.
// Build with PE_FEEDER_STALL_CNT_EN to also check the stall counter.
module tb_pe_array_feeder;

  localparam int DL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  klen;
  logic        busy, done;
  logic        dv, dr;
  logic [7:0]  dat;
  logic        wv, wr;
  logic [7:0]  wgt;
  logic [23:0] arr_data;
  logic [1:0]  arr_pass;
  logic [7:0]  arr_wgt;
  logic        arr_clr;
  logic [23:0] arr_res;
  logic        rv, rr;
  logic [7:0]  res;
  logic [1:0]  res_lane;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int clr_cnt  = 0;

  logic [33:0] iq[$];
  logic [15:0] rq[$];
  logic [23:0] cur;

  always #5 clk = ~clk;

  pe_array_feeder #(
    .ARRAY_NUM(3),
    .KMAX(16),
    .DRAIN_LAT(DL)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iStart(start),
    .iKernelLen(klen),
    .oBusy(busy),
    .oDone(done),
    .iDataValid(dv),
    .oDataReady(dr),
    .iData(dat),
    .iWeightValid(wv),
    .oWeightReady(wr),
    .iWeight(wgt),
    .oArrData(arr_data),
    .oArrPassLeft(arr_pass),
    .oArrWeight(arr_wgt),
    .oArrClearAcc(arr_clr),
    .iArrResult(arr_res),
`ifdef PE_FEEDER_STALL_CNT_EN
    .oStallCnt(stall_cnt),
`endif
    .oResultValid(rv),
    .iResultReady(rr),
    .oResult(res),
    .oResultLane(res_lane)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arr_clr) clr_cnt++;
    if (arr_wgt !== 8'h00) begin
      if (iq.size() == 0) begin
        chk("issue_unexpected", {arr_data, arr_pass, arr_wgt}, 0);
      end else begin
        chk("issue", {arr_data, arr_pass, arr_wgt},
            iq.pop_front());
      end
    end
    if (rv && rr) begin
      if (rq.size() == 0) begin
        chk("result_unexpected", {6'd0, res_lane, res}, 0);
      end else begin
        chk("result", {6'd0, res_lane, res}, rq.pop_front());
      end
    end
  end

  task automatic outs_zero(input string tag);
    logic [63:0] v;
    v = {busy, done, dr, wr, arr_data, arr_pass,
         arr_wgt, arr_clr, rv, res, res_lane};
`ifdef PE_FEEDER_STALL_CNT_EN
    v = v | {48'd0, stall_cnt};
`endif
    chk(tag, v, 0);
  endtask

  task automatic start_job(input logic [4:0] k);
    start = 1'b1;
    klen  = k;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    bit ok = 0;
    dv  = 1'b1;
    dat = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dr) begin
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    dv = 1'b0;
    chk("data_accept", ok, 1);
  endtask

  task automatic gather(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] c);
    send_data(a);
    send_data(b);
    send_data(c);
    cur = {c, b, a};
  endtask

  task automatic tap0(input logic [7:0] w);
    bit ok = 0;
    wv  = 1'b1;
    wgt = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr) begin
        ok = 1;
        iq.push_back({cur, 2'b00, w});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    wv = 1'b0;
    chk("tap0_accept", ok, 1);
  endtask

  task automatic issue(input logic [7:0] d,
                       input logic [7:0] w);
    bit ok = 0;
    dv  = 1'b1;
    wv  = 1'b1;
    dat = d;
    wgt = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dr && wr) begin
        ok = 1;
        cur[23:16] = d;
        iq.push_back({cur, 2'b11, w});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    dv = 1'b0;
    wv = 1'b0;
    chk("tapn_accept", ok, 1);
  endtask

  task automatic set_results(input logic [7:0] r0,
                             input logic [7:0] r1,
                             input logic [7:0] r2);
    arr_res = {r2, r1, r0};
    rq.push_back({8'd0, r0});
    rq.push_back({8'd1, r1});
    rq.push_back({8'd2, r2});
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int n;
    int zw;
    rst = 1'b1; start = 1'b0; klen = '0;
    dv = 1'b0; dat = '0; wv = 1'b0; wgt = '0;
    arr_res = '0; rr = 1'b1; cur = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    outs_zero("reset_outputs");
    @(posedge clk); #1;

    // Job A: K=2, no stalls, result ready toggling
    set_results(8'h10, 8'h20, 8'h30);
    start_job(5'd2);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    @(posedge clk); #1;
    gather(8'd1, 8'd2, 8'd3);
    tap0(8'd5);
    issue(8'd4, 8'd6);
    n = 0; zw = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rv) break;
      n++;
      if (arr_wgt == 8'h00) zw++;
    end
    chk("drain_cycles", n, DL + 1);
    chk("drain_zero_wgt", zw, DL);
    @(posedge clk); #1 rr = 1'b0;
    @(negedge clk);
    chk("stall_result", {res_lane, res}, {2'd1, 8'h20});
    @(posedge clk); #1 rr = 1'b1;
    @(negedge clk);
    chk("held_result", {res_lane, res}, {2'd1, 8'h20});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("clear_pulses_a", clr_cnt, 1);
`ifdef PE_FEEDER_STALL_CNT_EN
    chk("stall_cnt_a", stall_cnt, 0);
`endif
    @(posedge clk); #1;

    // Job B: data stalls for 3 cycles at k=1
    set_results(8'h41, 8'h42, 8'h43);
    start_job(5'd2);
    @(posedge clk); #1;
    gather(8'd1, 8'd2, 8'd3);
    tap0(8'd5);
    wv = 1'b1; wgt = 8'd6; dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        dv = 1'b1;
        dat = 8'd4;
      end
      @(negedge clk);
      if (i > 0) begin
        chk("bubble", {arr_data, arr_pass, arr_wgt},
            {24'h030201, 2'b00, 8'h00});
      end
      chk("wgt_ready_gate", wr, (i == 3));
      if (i == 3) begin
        cur[23:16] = 8'd4;
        iq.push_back({cur, 2'b11, 8'd6});
      end
      @(posedge clk); #1;
    end
    dv = 1'b0; wv = 1'b0;
`ifdef PE_FEEDER_STALL_CNT_EN
    @(negedge clk);
    chk("stall_cnt_b", stall_cnt, 3);
    @(posedge clk); #1;
`endif
    wait_done("done_b");

    // Illegal and mid-job starts are ignored
    dv = 1'b1; dat = 8'hEE;
    start = 1'b1; klen = 5'd0;
    @(negedge clk);
    chk("k0_no_consume", dr, 0);
    @(posedge clk); #1;
    klen = 5'd17;
    @(negedge clk);
    chk("k0_ignored", busy, 0);
    chk("k17_no_consume", dr, 0);
    @(posedge clk); #1;
    start = 1'b0; dv = 1'b0;
    @(negedge clk);
    chk("k17_ignored", busy, 0);
    @(posedge clk); #1;

    set_results(8'h51, 8'h52, 8'h53);
    start_job(5'd1);
    @(posedge clk); #1;
    send_data(8'h11);
    start = 1'b1; klen = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("midjob_busy", {busy, dr}, 2'b11);
    @(posedge clk); #1;
    send_data(8'h12);
    send_data(8'h13);
    cur = 24'h131211;
    tap0(8'h21);
    wait_done("done_c_k1");

    // Reset during STEP at k=1, then a fresh K=1 job
    start_job(5'd3);
    @(posedge clk); #1;
    gather(8'h31, 8'h32, 8'h33);
    tap0(8'd7);
    rst = 1'b1; dv = 1'b1; wv = 1'b1;
    dat = 8'h99; wgt = 8'h98;
    @(negedge clk);
    chk("reset_no_consume", {dr, wr}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0; wv = 1'b0;
    @(negedge clk);
    outs_zero("midjob_reset_outputs");
    @(posedge clk); #1;
    set_results(8'h61, 8'h62, 8'h63);
    start_job(5'd1);
    @(posedge clk); #1;
    gather(8'h71, 8'h72, 8'h73);
    tap0(8'h22);
    wait_done("done_after_reset");

    // Back-to-back K=1 jobs
    set_results(8'h81, 8'h82, 8'h83);
    start_job(5'd1);
    @(posedge clk); #1;
    gather(8'h01, 8'h02, 8'h03);
    tap0(8'h23);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        n = 1;
        break;
      end
    end
    chk("done_b2b_1", n, 1);
    start = 1'b1; klen = 5'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_on_done_ignored", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_after_done", busy, 1);
    set_results(8'h91, 8'h92, 8'h93);
    @(posedge clk); #1;
    gather(8'h04, 8'h05, 8'h06);
    tap0(8'h24);
    wait_done("done_b2b_2");

    chk("clear_pulses_total", clr_cnt, 7);
    chk("issue_queue_empty", iq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
